// File: rtl/explorer_pkg.sv
// explorer_pkg: shared types and the fixed move script for the explorer
// command generator. Directions are encoded as dir_e. Each output pulse
// vector is ordered {n, s, e, w}.
package explorer_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4,
    FAIL   = 3'd5
  } state_e;

  localparam int         SCRIPT_LEN   = 5;
  localparam logic [3:0] SCRIPT_LEN_4 = 4'(SCRIPT_LEN);

  // Route from the entrance to the treasure room.
  localparam dir_e SCRIPT [SCRIPT_LEN] = '{DIR_E, DIR_S, DIR_W, DIR_E, DIR_E};

  // Script lookup. An index past the end of the script falls back to a
  // fixed entry so that the lookup never reads outside the table.
  function automatic dir_e script_dir(input logic [3:0] idx);
    dir_e d;
    case (idx)
      4'd0:    d = SCRIPT[0];
      4'd1:    d = SCRIPT[1];
      4'd2:    d = SCRIPT[2];
      4'd3:    d = SCRIPT[3];
      4'd4:    d = SCRIPT[4];
      default: d = DIR_E;
    endcase
    return d;
  endfunction

  // One-hot pulse vector {n, s, e, w} for a direction.
  function automatic logic [3:0] dir_pulse(input dir_e d);
    logic [3:0] p;
    case (d)
      DIR_N:   p = 4'b1000;
      DIR_S:   p = 4'b0100;
      DIR_E:   p = 4'b0010;
      DIR_W:   p = 4'b0001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/explorer_timeout.sv
// explorer_timeout: wait-window counter for the explorer command generator.
// load clears the counter. count advances it until it reaches
// TIMEOUT_CYCLES-1, where it stops. expired is high while the counter
// sits at that last value.
module explorer_timeout
  import explorer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counter: a load wins over count, and the counter stops at the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= {CW{1'b0}};
    end else if (count && (cnt != LAST)) begin
      cnt <= cnt + CW'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/explorer_cmd_gen.sv
// explorer_cmd_gen: plays the fixed move script into the room FSM. For each
// entry it issues one direction pulse. It then waits for the room to change,
// re-issuing the pulse on timeout. It reports done on a win and fail on
// death, a timeout or exhausted retries.
// Optional build macro EXPLORER_MANUAL_EN adds the btn_n/btn_s/btn_e/btn_w
// inputs. In IDLE, a rising edge on one of these sends a single pulse on the
// matching direction output.
module explorer_cmd_gen
  import explorer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] room,
  input  logic       sw_in,
  input  logic       wz_in,
  input  logic       win_in,
  input  logic       d_in,
`ifdef EXPLORER_MANUAL_EN
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
`endif
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       v,
  output logic       h,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] step
);

  localparam int            RW         = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  state_e        state;
  logic [RW-1:0] retry;
  logic [8:0]    snapshot;
  logic          room_changed;
  logic [3:0]    step_inc;
  logic          tmo_load;
  logic          tmo_count;
  logic          tmo_expired;

  assign room_changed = (room != snapshot);
  assign step_inc     = step + 4'd1;

  // Timer control. The counter is held at zero in IDLE so that the first
  // ISSUE starts a fresh window. The window covers ISSUE plus WAIT, so one
  // attempt spans exactly TIMEOUT_CYCLES cycles. FINISH gets its own window.
  always_comb begin
    tmo_load  = 1'b0;
    tmo_count = 1'b0;
    case (state)
      IDLE: begin
        tmo_load = 1'b1;
      end
      ISSUE: begin
        tmo_count = 1'b1;
      end
      WAIT: begin
        if (room_changed || tmo_expired) begin
          tmo_load = 1'b1;
        end else begin
          tmo_count = 1'b1;
        end
      end
      FINISH: begin
        tmo_count = 1'b1;
      end
      default: begin
        tmo_load  = 1'b0;
        tmo_count = 1'b0;
      end
    endcase
  end

  explorer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (tmo_load),
    .count  (tmo_count),
    .expired(tmo_expired)
  );

`ifdef EXPLORER_MANUAL_EN
  logic btn_n_q;
  logic btn_s_q;
  logic btn_e_q;
  logic btn_w_q;

  // Previous button levels, kept for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_n_q <= 1'b0;
      btn_s_q <= 1'b0;
      btn_e_q <= 1'b0;
      btn_w_q <= 1'b0;
    end else begin
      btn_n_q <= btn_n;
      btn_s_q <= btn_s;
      btn_e_q <= btn_e;
      btn_w_q <= btn_w;
    end
  end
`endif

  // Playback FSM with registered outputs. A direction pulse is loaded on the
  // same edge that enters ISSUE, so the pulse is high exactly while the FSM
  // is in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 4'd0;
      retry    <= {RW{1'b0}};
      snapshot <= 9'd0;
      {n, s, e, w} <= 4'b0000;
      v        <= 1'b0;
      h        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      v <= sw_in;
      h <= wz_in;
      {n, s, e, w} <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            step  <= 4'd0;
            retry <= {RW{1'b0}};
            busy  <= 1'b1;
            state <= ISSUE;
            {n, s, e, w} <= dir_pulse(script_dir(4'd0));
          end
`ifdef EXPLORER_MANUAL_EN
          else begin
            {n, s, e, w} <= {btn_n & ~btn_n_q, btn_s & ~btn_s_q,
                             btn_e & ~btn_e_q, btn_w & ~btn_w_q};
          end
`endif
        end
        ISSUE: begin
          snapshot <= room;
          if (d_in) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (d_in) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end else if (room_changed) begin
            retry <= {RW{1'b0}};
            if (step != SCRIPT_LEN_4) begin
              step <= step_inc;
            end else begin
              step <= step;
            end
            if (step_inc < SCRIPT_LEN_4) begin
              state <= ISSUE;
              {n, s, e, w} <= dir_pulse(script_dir(step_inc));
            end else begin
              state <= FINISH;
            end
          end else if (tmo_expired) begin
            if (retry == RETRY_LAST) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= FAIL;
            end else begin
              retry <= retry + RW'(1'b1);
              state <= ISSUE;
              {n, s, e, w} <= dir_pulse(script_dir(step));
            end
          end else begin
            state <= WAIT;
          end
        end
        FINISH: begin
          if (win_in) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (d_in || tmo_expired) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end else begin
            state <= FINISH;
          end
        end
        DONE, FAIL: begin
          state <= state;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_explorer_cmd_gen.sv
// tb_explorer_cmd_gen: scoreboard bench for explorer_cmd_gen. A small room
// FSM model rotates the one-hot room one cycle after each direction pulse,
// within a per-test move budget. The expected pulses {n,s,e,w} and their
// step values are queued when a test starts the script. Observed pulses are
// queued by tick() and compared against the expected queue.
// Build with EXPLORER_MANUAL_EN to add the manual-button scenario.
module tb_explorer_cmd_gen;

  localparam logic [3:0] P_E = 4'b0010;
  localparam logic [3:0] P_S = 4'b0100;
  localparam logic [3:0] P_W = 4'b0001;

  typedef struct {
    logic [3:0] dirs;
    logic [3:0] step;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, start, sw_in, wz_in, win_in, d_in;
  logic [8:0] room;
  logic       n, s, e, w, v, h, busy, done, fail;
  logic [3:0] step;
`ifdef EXPLORER_MANUAL_EN
  logic       btn_n, btn_s, btn_e, btn_w;
`endif

  int   vectors      = 0;
  int   miscompares  = 0;
  int   tick_cnt     = 0;
  int   moves_left   = 0;
  logic move_pending = 1'b0;
  ev_t  sb[$];
  ev_t  obs[$];

  always #5 clk = ~clk;

  explorer_cmd_gen #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .room(room),
    .sw_in(sw_in), .wz_in(wz_in), .win_in(win_in), .d_in(d_in),
`ifdef EXPLORER_MANUAL_EN
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
`endif
    .n(n), .s(s), .e(e), .w(w), .v(v), .h(h),
    .busy(busy), .done(done), .fail(fail), .step(step)
  );

  // Advance one cycle and sample at the falling edge. Record any pulse, and
  // let the room model answer a pulse one cycle later (budget -1 = unlimited).
  task automatic tick();
    ev_t ev;
    @(negedge clk);
    tick_cnt++;
    if (move_pending) begin
      room = {room[7:0], room[8]};
      move_pending = 1'b0;
    end
    if ({n, s, e, w} != 4'b0000) begin
      ev.dirs = {n, s, e, w};
      ev.step = step;
      ev.cyc  = tick_cnt;
      obs.push_back(ev);
      if (moves_left != 0) begin
        move_pending = 1'b1;
        if (moves_left > 0) moves_left--;
      end
    end
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [3:0] st);
    ev_t x;
    x.dirs = d;
    x.step = st;
    x.cyc  = 0;
    sb.push_back(x);
  endtask

  task automatic push_script(input int count);
    logic [3:0] tbl [5];
    tbl = '{P_E, P_S, P_W, P_E, P_E};
    for (int i = 0; i < count; i++) push_exp(tbl[i], 4'(i));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sw_in = 1'b0; wz_in = 1'b0;
    win_in = 1'b0; d_in = 1'b0; room = 9'b000000001;
`ifdef EXPLORER_MANUAL_EN
    btn_n = 1'b0; btn_s = 1'b0; btn_e = 1'b0; btn_w = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    obs.delete();
    move_pending = 1'b0;
    moves_left = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({n, s, e, w, v, h, busy, done, fail} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=000000000", {n, s, e, w, v, h, busy, done, fail});
    end
    vectors++;
    if (step !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_step got=%0d want=0", step);
    end
  endtask

  task automatic test_script();
    ev_t o, x;
    do_reset();
    moves_left = -1;
    push_script(5);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      if (i > 0) tick();
      while (obs.size() != 0 && sb.size() != 0) begin
        o = obs.pop_front(); x = sb.pop_front();
        vectors++;
        if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
          miscompares++;
          $display("FAIL script_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL script_drain got pending=%0d want 0", sb.size());
    end
    for (int i = 0; i < 10 && step !== 4'd5; i++) tick();
    vectors++;
    if ({step, busy, done} !== {4'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL script_finish got step=%0d busy=%b done=%b want 5 1 0", step, busy, done);
    end
    win_in = 1'b1; tick(); win_in = 1'b0;
    vectors++;
    if ({done, busy, fail, step} !== {1'b1, 1'b0, 1'b0, 4'd5}) begin
      miscompares++;
      $display("FAIL script_done got done=%b busy=%b fail=%b step=%0d want 1 0 0 5", done, busy, fail, step);
    end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    vectors++;
    if ({done, busy, fail, step} !== {1'b1, 1'b0, 1'b0, 4'd5} || obs.size() != 0) begin
      miscompares++;
      $display("FAIL done_sticky got done=%b busy=%b step=%0d extra=%0d want 1 0 5 0", done, busy, step, obs.size());
    end
  endtask

  task automatic test_timeout();
    ev_t o, x;
    int  c[$];
    int  fail_tick;
    do_reset();
    room = 9'b000000010;
    moves_left = 0;
    push_exp(P_E, 4'd0); push_exp(P_E, 4'd0); push_exp(P_E, 4'd0);
    start = 1'b1; tick(); start = 1'b0;
    fail_tick = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fail === 1'b1) begin
        fail_tick = tick_cnt;
        break;
      end
    end
    while (obs.size() != 0 && sb.size() != 0) begin
      o = obs.pop_front(); x = sb.pop_front();
      c.push_back(o.cyc);
      vectors++;
      if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
        miscompares++;
        $display("FAIL retry_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
      end
    end
    vectors++;
    if (c.size() != 3 || obs.size() != 0) begin
      miscompares++;
      $display("FAIL retry_count got=%0d extra=%0d want 3 0", c.size(), obs.size());
    end else begin
      if (c[1] - c[0] !== 16 || c[2] - c[0] !== 32) begin
        miscompares++;
        $display("FAIL retry_spacing got=%0d,%0d want 16,32", c[1] - c[0], c[2] - c[0]);
      end
      vectors++;
      if (fail_tick - c[0] !== 48) begin
        miscompares++;
        $display("FAIL retry_fail_time got=%0d want 48", fail_tick - c[0]);
      end
    end
    vectors++;
    if ({fail, busy, done, step} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL retry_final got fail=%b busy=%b done=%b step=%0d want 1 0 0 0", fail, busy, done, step);
    end
  endtask

  task automatic test_death();
    ev_t o, x;
    do_reset();
    moves_left = 2;
    push_script(3);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      if (i > 0) tick();
      while (obs.size() != 0 && sb.size() != 0) begin
        o = obs.pop_front(); x = sb.pop_front();
        vectors++;
        if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
          miscompares++;
          $display("FAIL death_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
        end
      end
    end
    tick();
    d_in = 1'b1; tick(); d_in = 1'b0;
    vectors++;
    if ({fail, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL death_fail got fail=%b busy=%b done=%b want 1 0 0", fail, busy, done);
    end
    repeat (20) tick();
    vectors++;
    if (obs.size() != 0 || fail !== 1'b1 || step !== 4'd2) begin
      miscompares++;
      $display("FAIL death_hold got extra=%0d fail=%b step=%0d want 0 1 2", obs.size(), fail, step);
    end
  endtask

  task automatic test_reset_restart();
    ev_t o, x;
    do_reset();
    moves_left = 3;
    push_script(4);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      if (i > 0) tick();
      while (obs.size() != 0 && sb.size() != 0) begin
        o = obs.pop_front(); x = sb.pop_front();
        vectors++;
        if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
          miscompares++;
          $display("FAIL midrst_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
        end
      end
    end
    tick();
    vectors++;
    if ({step, busy} !== {4'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_wait got step=%0d busy=%b want 3 1", step, busy);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({n, s, e, w, v, h, busy, done, fail, step} !== 13'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got=%b step=%0d want all 0", {n, s, e, w, v, h, busy, done, fail}, step);
    end
    move_pending = 1'b0;
    obs.delete();
    moves_left = -1;
    push_script(5);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      if (i > 0) tick();
      while (obs.size() != 0 && sb.size() != 0) begin
        o = obs.pop_front(); x = sb.pop_front();
        vectors++;
        if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
          miscompares++;
          $display("FAIL restart_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
        end
      end
    end
    for (int i = 0; i < 10 && step !== 4'd5; i++) tick();
    win_in = 1'b1; d_in = 1'b1; tick(); win_in = 1'b0; d_in = 1'b0;
    vectors++;
    if ({done, fail, busy, step} !== {1'b1, 1'b0, 1'b0, 4'd5} || sb.size() != 0) begin
      miscompares++;
      $display("FAIL restart_done got done=%b fail=%b busy=%b step=%0d pending=%0d want 1 0 0 5 0", done, fail, busy, step, sb.size());
    end
  endtask

  task automatic test_levels_busy_start();
    ev_t o, x;
    do_reset();
    sw_in = 1'b1; wz_in = 1'b1; tick();
    vectors++;
    if ({v, h} !== 2'b11) begin
      miscompares++;
      $display("FAIL level_rise got v=%b h=%b want 1 1", v, h);
    end
    sw_in = 1'b0; wz_in = 1'b0; #1;
    vectors++;
    if ({v, h} !== 2'b11) begin
      miscompares++;
      $display("FAIL level_registered got v=%b h=%b want 1 1", v, h);
    end
    tick();
    vectors++;
    if ({v, h} !== 2'b00) begin
      miscompares++;
      $display("FAIL level_fall got v=%b h=%b want 0 0", v, h);
    end
    moves_left = 0;
    push_exp(P_E, 4'd0);
    start = 1'b1; tick(); start = 1'b0;
    while (obs.size() != 0 && sb.size() != 0) begin
      o = obs.pop_front(); x = sb.pop_front();
      vectors++;
      if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
        miscompares++;
        $display("FAIL busy_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
      end
    end
    tick();
    start = 1'b1; repeat (6) tick(); start = 1'b0; tick();
    vectors++;
    if ({step, busy, done, fail} !== {4'd0, 1'b1, 1'b0, 1'b0} || obs.size() != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL busy_start got step=%0d busy=%b extra=%0d pending=%0d want 0 1 0 0", step, busy, obs.size(), sb.size());
    end
    do_reset();
  endtask

`ifdef EXPLORER_MANUAL_EN
  task automatic test_manual();
    ev_t o, x;
    do_reset();
    push_exp(P_W, 4'd0);
    btn_w = 1'b1; repeat (5) tick(); btn_w = 1'b0; repeat (3) tick();
    while (obs.size() != 0 && sb.size() != 0) begin
      o = obs.pop_front(); x = sb.pop_front();
      vectors++;
      if ({o.dirs, o.step} !== {x.dirs, x.step}) begin
        miscompares++;
        $display("FAIL manual_pulse got dir=%b step=%0d want dir=%b step=%0d", o.dirs, o.step, x.dirs, x.step);
      end
    end
    vectors++;
    if (obs.size() != 0 || sb.size() != 0 || {busy, done, fail, step} !== 7'b0) begin
      miscompares++;
      $display("FAIL manual_single got extra=%0d pending=%0d busy=%b step=%0d want 0 0 0 0", obs.size(), sb.size(), busy, step);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_script();
    test_timeout();
    test_death();
    test_reset_restart();
    test_levels_busy_start();
`ifdef EXPLORER_MANUAL_EN
    test_manual();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
